aes128_enc_iter: RTL and testbench

- Iterative AES-128 encryption engine, FIPS-197. It is the forward (cipher) counterpart of the decryption datapath in this codebase.
- Computes one round per clock and expands round keys on the fly.
- Sits beside the decryption core and shares the same 128-bit state byte ordering: bits [127:120] = byte 0 = s(0,0), column-major, so byte n = s(n mod 4, n div 4).
- Uses valid/ready handshakes on both input and output.

---
 rtl/aes_pkg.sv | 47 ++++
 rtl/aes_shift_rows.sv | 12 +
 rtl/aes128_enc_iter.sv | 92 +++++++++
 tb/tb_aes128_enc_iter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants and byte-level helpers for the iterative cipher datapath.
// State byte n sits at bits [127-8n -: 8], column-major.
package aes_pkg;

  localparam int AES_NR = 10;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUND = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Counter value outside 1..10 only occurs outside ROUND, where the result is unused.
  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    return (r >= 4'd1 && r <= 4'd10) ? RCON[r] : 8'h00;
  endfunction

endpackage

// File: rtl/aes_shift_rows.sv
// Combinational AES ShiftRows on a column-major 128-bit state.
module aes_shift_rows (
  input  logic [127:0] state,
  output logic [127:0] shifted
);

  // Row r rotates left by r: out byte n takes in byte (n + 4*(n mod 4)) mod 16.
  for (genvar n = 0; n < 16; n++) begin : g_byte
    assign shifted[127-8*n -: 8] = state[127-8*((n + 4*(n % 4)) % 16) -: 8];
  end

endmodule

// File: rtl/aes128_enc_iter.sv
// Iterative AES-128 encryptor: one round per clock, round keys expanded on the fly.
// Accepts a block in IDLE, runs ten rounds in ROUND, presents the result in DONE.
module aes128_enc_iter
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] key,
  input  logic [127:0] plaintext,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy
);

  logic [1:0]   fsm;
  logic [3:0]   round;
  logic [127:0] state_reg, rk_reg;
  logic [127:0] sb, sr, mc, rk_next, round_out;
  logic         last;

  assign last = (round == 4'(NR));

  for (genvar n = 0; n < 16; n++) begin : g_sub
    assign sb[127-8*n -: 8] = sbox(state_reg[127-8*n -: 8]);
  end

  aes_shift_rows u_shift_rows (
    .state   (sb),
    .shifted (sr)
  );

  for (genvar c = 0; c < 4; c++) begin : g_mix
    logic [7:0] a0, a1, a2, a3;
    assign a0 = sr[127-32*c -: 8];
    assign a1 = sr[119-32*c -: 8];
    assign a2 = sr[111-32*c -: 8];
    assign a3 = sr[103-32*c -: 8];
    assign mc[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign mc[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign mc[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign mc[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

  // Next round key: t = SubWord(RotWord(w3)) ^ {RCON, 24'h0}, then a running xor.
  logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
  assign {w0, w1, w2, w3} = rk_reg;
  assign t  = {sbox(w3[23:16]) ^ rcon_of(round), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign rk_next = {n0, n1, n2, n3};

  assign round_out = (last ? sr : mc) ^ rk_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= IDLE;
      round     <= '0;
      state_reg <= '0;
      rk_reg    <= '0;
    end else begin
      case (fsm)
        IDLE: if (in_valid) begin
          state_reg <= plaintext ^ key;
          rk_reg    <= key;
          round     <= 4'd1;
          fsm       <= ROUND;
        end
        ROUND: begin
          state_reg <= round_out;
          rk_reg    <= rk_next;
          round     <= round + 4'd1;
          if (last) fsm <= DONE;
        end
        DONE: if (out_ready) fsm <= IDLE;
        default: fsm <= IDLE;
      endcase
    end
  end

  assign in_ready   = (fsm == IDLE);
  assign busy       = (fsm == ROUND);
  assign out_valid  = (fsm == DONE);
  assign ciphertext = state_reg;

endmodule

// File: tb/tb_aes128_enc_iter.sv
// Directed FIPS-197 vectors, handshake timing, backpressure and mid-run reset.
module tb_aes128_enc_iter;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] RB1 = 128'ha49c7ff2689f352b6b5bea43026a5049;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] key = '0;
  logic [127:0] plaintext = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] ciphertext;
  logic         busy;
  logic [127:0] sr_in = '0;
  logic [127:0] sr_out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  aes128_enc_iter dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .key        (key),
    .plaintext  (plaintext),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext),
    .busy       (busy)
  );

  aes_shift_rows u_sr (
    .state   (sr_in),
    .shifted (sr_out)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic send(input logic [127:0] k, input logic [127:0] p);
    int t;
    t = 0;
    key = k; plaintext = p; in_valid = 1'b1;
    while (!in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("accept", 128'(in_ready), 128'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts cycles from the handshake cycle (index 0) until out_valid.
  task automatic wait_done(input int start, output int lat);
    lat = start;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic stable;
    logic pend;
    int acc[$];
    int outc[$];
    logic [127:0] res[$];

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_ct", ciphertext, 128'd0);
    chk("rst_round", 128'(dut.round), 128'd0);
    rst = 1'b0;
    @(negedge clk);

    sr_in = 128'h000102030405060708090a0b0c0d0e0f;
    #1;
    chk("shift_rows", sr_out, 128'h00050a0f04090e03080d02070c01060b);

    // FIPS-197 C.1 with latency
    @(negedge clk);
    send(K1, P1);
    chk("c1_busy", 128'(busy), 128'd1);
    wait_done(1, lat);
    chk("c1_latency", 128'(lat), 128'd11);
    chk("c1_ct", ciphertext, C1);
    consume();
    chk("c1_drained", 128'(out_valid), 128'd0);

    // FIPS-197 App. B with round-1 probe
    send(KB, PB);
    chk("b_r0", dut.state_reg, PB ^ KB);
    @(negedge clk);
    chk("b_r1", dut.state_reg, RB1);
    wait_done(2, lat);
    chk("b_latency", 128'(lat), 128'd11);
    chk("b_ct", ciphertext, CB);
    consume();

    // Backpressure: hold DONE 20 cycles while a second block waits
    send(K1, P1);
    wait_done(1, lat);
    key = KB; plaintext = PB; in_valid = 1'b1;
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (ciphertext !== C1 || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0)
        stable = 1'b0;
    end
    chk("bp_hold", 128'(stable), 128'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_idle_valid", 128'(out_valid), 128'd0);
    chk("bp_idle_ready", 128'(in_ready), 128'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_accepted", 128'(busy), 128'd1);
    wait_done(1, lat);
    chk("bp_latency", 128'(lat), 128'd11);
    chk("bp_ct", ciphertext, CB);
    consume();

    // Reset in the middle of round processing
    send(K1, P1);
    repeat (4) @(negedge clk);
    chk("mid_round", 128'(dut.round), 128'd5);
    rst = 1'b1;
    #1;
    chk("mid_out_valid", 128'(out_valid), 128'd0);
    chk("mid_in_ready", 128'(in_ready), 128'd1);
    chk("mid_ct", ciphertext, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(K1, P1);
    wait_done(1, lat);
    chk("post_rst_ct", ciphertext, C1);
    consume();

    // Back-to-back with in_valid held and out_ready tied high
    pend = 1'b0;
    key = K1; plaintext = P1; in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (pend) begin
        if (acc.size() == 1) begin
          key = KB; plaintext = PB;
        end else begin
          in_valid = 1'b0;
        end
        pend = 1'b0;
      end
      if (in_valid && in_ready) begin
        acc.push_back(cyc);
        pend = 1'b1;
      end
      if (out_valid) begin
        outc.push_back(cyc);
        res.push_back(ciphertext);
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("b2b_accepts", 128'(acc.size()), 128'd2);
    chk("b2b_outputs", 128'(outc.size()), 128'd2);
    if (acc.size() >= 2 && outc.size() >= 2) begin
      chk("b2b_acc_gap", 128'(acc[1] - acc[0]), 128'd12);
      chk("b2b_out_gap", 128'(outc[1] - outc[0]), 128'd12);
      chk("b2b_first_lat", 128'(outc[0] - acc[0]), 128'd11);
      chk("b2b_ct0", res[0], C1);
      chk("b2b_ct1", res[1], CB);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
